// File: rtl/ex_muldiv_controller.sv
// ex_muldiv_controller
//   Sequencer for the EX-stage iterative multiply/divide unit. Decodes the R-type
//   HI/LO instructions, runs a one-bit-per-cycle shift-add multiply or restoring
//   divide on operand magnitudes, applies the sign fix-up and owns HI/LO.
//
// Ports
//   Clk              pipeline clock, rising edge
//   Reset            asynchronous, active-high
//   ALUOp_EX         2'b10 selects R-type decode; other values are ignored
//   Funct_EX         instruction funct field
//   Flush_EX         aborts any operation, HI/LO left untouched
//   A_EX, B_EX       rs / rt operands
//   Stall_EX         holds IF/ID/EX while the unit is busy
//   HI, LO           architectural HI/LO registers
//   MulDiv_Result_EX MFHI/MFLO read data, 0 for other functs
//   Done_EX          one-cycle completion pulse
//   DivByZero_EX     one-cycle pulse when a divide had a zero divisor
module ex_muldiv_controller #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [1:0]       ALUOp_EX,
    input  logic [5:0]       Funct_EX,
    input  logic             Flush_EX,
    input  logic [WIDTH-1:0] A_EX,
    input  logic [WIDTH-1:0] B_EX,
    output logic             Stall_EX,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic [WIDTH-1:0] MulDiv_Result_EX,
    output logic             Done_EX,
    output logic             DivByZero_EX
);

    localparam logic [5:0] FnMfhi  = 6'b010000;
    localparam logic [5:0] FnMthi  = 6'b010001;
    localparam logic [5:0] FnMflo  = 6'b010010;
    localparam logic [5:0] FnMtlo  = 6'b010011;
    localparam logic [5:0] FnMult  = 6'b011000;
    localparam logic [5:0] FnMultu = 6'b011001;
    localparam logic [5:0] FnDiv   = 6'b011010;
    localparam logic [5:0] FnDivu  = 6'b011011;

    localparam logic [WIDTH-1:0]   OneW    = WIDTH'(1);
    localparam logic [2*WIDTH-1:0] OneD    = (2 * WIDTH)'(1);
    localparam logic [CNT_W-1:0]   CntLast = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0]   CntOne  = CNT_W'(1);

    typedef enum logic [2:0] {
        StIdle,
        StMul,
        StDiv,
        StFixup,
        StDone
    } state_e;

    // State
    state_e             r_state;
    logic [CNT_W-1:0]   r_cnt;
    // Multiply: {partial product high, multiplier shifting out}.
    // Divide:   {partial remainder, dividend shifting out / quotient shifting in}.
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_opnd;   // multiplicand or divisor magnitude
    logic               r_neg_q;  // negate product / quotient at fix-up
    logic               r_neg_r;  // negate remainder at fix-up
    logic               r_is_div;
    logic               r_dbz;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    // Next-state
    state_e             w_state_next;
    logic [CNT_W-1:0]   w_cnt_next;
    logic [2*WIDTH-1:0] w_acc_next;
    logic [WIDTH-1:0]   w_opnd_next;
    logic               w_neg_q_next;
    logic               w_neg_r_next;
    logic               w_is_div_next;
    logic               w_dbz_next;
    logic [WIDTH-1:0]   w_hi_next;
    logic [WIDTH-1:0]   w_lo_next;

    // Decode
    logic w_rtype;
    logic w_op_mul;
    logic w_op_div;
    logic w_op_signed;
    logic w_op_mthi;
    logic w_op_mtlo;
    logic w_op_mfhi;
    logic w_op_mflo;

    assign w_rtype     = (ALUOp_EX == 2'b10);
    assign w_op_mul    = w_rtype && ((Funct_EX == FnMult) || (Funct_EX == FnMultu));
    assign w_op_div    = w_rtype && ((Funct_EX == FnDiv) || (Funct_EX == FnDivu));
    assign w_op_signed = w_rtype && ((Funct_EX == FnMult) || (Funct_EX == FnDiv));
    assign w_op_mthi   = w_rtype && (Funct_EX == FnMthi);
    assign w_op_mtlo   = w_rtype && (Funct_EX == FnMtlo);
    assign w_op_mfhi   = w_rtype && (Funct_EX == FnMfhi);
    assign w_op_mflo   = w_rtype && (Funct_EX == FnMflo);

    // Operand magnitudes; 0x80000000 maps to itself, which is the correct
    // unsigned magnitude 2^31.
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_abs;
    logic [WIDTH-1:0] w_b_abs;

    assign w_a_neg = w_op_signed && A_EX[WIDTH-1];
    assign w_b_neg = w_op_signed && B_EX[WIDTH-1];
    assign w_a_abs = w_a_neg ? (~A_EX + OneW) : A_EX;
    assign w_b_abs = w_b_neg ? (~B_EX + OneW) : B_EX;

    // Shift-add multiply step: add multiplicand to the high half when the
    // multiplier LSB is set, then shift the whole accumulator right with carry.
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_step;

    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} +
                        {1'b0, (r_acc[0] ? r_opnd : {WIDTH{1'b0}})};
    assign w_mul_step = {w_mul_sum, r_acc[WIDTH-1:1]};

    // Restoring divide step. The partial remainder is always below the
    // divisor, so the difference fits in WIDTH bits whenever it is taken.
    logic [WIDTH:0]     w_div_shift;
    logic               w_div_ge;
    logic [WIDTH-1:0]   w_div_sub;
    logic [2*WIDTH-1:0] w_div_step;

    assign w_div_shift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_div_ge    = (w_div_shift >= {1'b0, r_opnd});
    assign w_div_sub   = w_div_shift[WIDTH-1:0] - r_opnd;
    assign w_div_step  = {(w_div_ge ? w_div_sub : w_div_shift[WIDTH-1:0]),
                          r_acc[WIDTH-2:0], w_div_ge};

    // Sign fix-up
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;

    assign w_prod_fix = r_neg_q ? (~r_acc + OneD) : r_acc;
    assign w_quo_fix  = r_neg_q ? (~r_acc[WIDTH-1:0] + OneW) : r_acc[WIDTH-1:0];
    assign w_rem_fix  = r_neg_r ? (~r_acc[2*WIDTH-1:WIDTH] + OneW)
                                : r_acc[2*WIDTH-1:WIDTH];

    logic w_last;
    assign w_last = (r_cnt == CntLast);

    // Next-state and control outputs
    always_comb begin
        w_state_next  = r_state;
        w_cnt_next    = r_cnt;
        w_acc_next    = r_acc;
        w_opnd_next   = r_opnd;
        w_neg_q_next  = r_neg_q;
        w_neg_r_next  = r_neg_r;
        w_is_div_next = r_is_div;
        w_dbz_next    = r_dbz;
        w_hi_next     = r_hi;
        w_lo_next     = r_lo;
        Stall_EX      = 1'b0;
        Done_EX       = 1'b0;
        DivByZero_EX  = 1'b0;

        if (Flush_EX) begin
            // Abort wins over everything, including a start in this cycle.
            w_state_next = StIdle;
        end else begin
            case (r_state)
                StIdle: begin
                    // Reset gating keeps Stall_EX low while Reset is held with a
                    // multiply/divide still sitting in EX.
                    if ((w_op_mul || w_op_div) && !Reset) begin
                        Stall_EX      = 1'b1;
                        w_cnt_next    = '0;
                        w_neg_q_next  = w_a_neg ^ w_b_neg;
                        w_neg_r_next  = w_a_neg;
                        w_is_div_next = w_op_div;
                        w_dbz_next    = w_op_div && (B_EX == '0);
                        if (w_op_mul) begin
                            w_acc_next   = {{WIDTH{1'b0}}, w_b_abs};
                            w_opnd_next  = w_a_abs;
                            w_state_next = StMul;
                        end else begin
                            w_acc_next   = {{WIDTH{1'b0}}, w_a_abs};
                            w_opnd_next  = w_b_abs;
                            w_state_next = (B_EX == '0) ? StDone : StDiv;
                        end
                    end else begin
                        if (w_op_mthi) w_hi_next = A_EX;
                        if (w_op_mtlo) w_lo_next = A_EX;
                    end
                end
                // Busy states stall unconditionally, which also covers an
                // MFHI/MFLO arriving while the unit is running.
                StMul: begin
                    Stall_EX   = 1'b1;
                    w_acc_next = w_mul_step;
                    w_cnt_next = r_cnt + CntOne;
                    if (w_last) w_state_next = StFixup;
                end
                StDiv: begin
                    Stall_EX   = 1'b1;
                    w_acc_next = w_div_step;
                    w_cnt_next = r_cnt + CntOne;
                    if (w_last) w_state_next = StFixup;
                end
                StFixup: begin
                    Stall_EX = 1'b1;
                    if (r_is_div) begin
                        w_hi_next = w_rem_fix;
                        w_lo_next = w_quo_fix;
                    end else begin
                        w_hi_next = w_prod_fix[2*WIDTH-1:WIDTH];
                        w_lo_next = w_prod_fix[WIDTH-1:0];
                    end
                    w_state_next = StDone;
                end
                StDone: begin
                    // The issuing instruction is still in EX; do not restart.
                    Done_EX      = 1'b1;
                    DivByZero_EX = r_dbz;
                    w_state_next = StIdle;
                end
                default: w_state_next = StIdle;
            endcase
        end
    end

    always_comb begin
        MulDiv_Result_EX = '0;
        if (w_op_mfhi) MulDiv_Result_EX = r_hi;
        if (w_op_mflo) MulDiv_Result_EX = r_lo;
    end

    assign HI = r_hi;
    assign LO = r_lo;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state  <= StIdle;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_opnd   <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_is_div <= 1'b0;
            r_dbz    <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            r_state  <= w_state_next;
            r_cnt    <= w_cnt_next;
            r_acc    <= w_acc_next;
            r_opnd   <= w_opnd_next;
            r_neg_q  <= w_neg_q_next;
            r_neg_r  <= w_neg_r_next;
            r_is_div <= w_is_div_next;
            r_dbz    <= w_dbz_next;
            r_hi     <= w_hi_next;
            r_lo     <= w_lo_next;
        end
    end

endmodule
